// File: rtl/mips_controller.sv
// ============================================================================
//  Module   : mips_controller
//  Purpose  : Multicycle control FSM and ALU decoder for the 8-bit TinyMIPS.
//             Optional ADDI support is built when ADDI_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_controller #(
   parameter logic [5:0] OP_LB    = 6'b100000,
   parameter logic [5:0] OP_SB    = 6'b101000,
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010,
   parameter logic [5:0] OP_ADDI  = 6'b001000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       memread,
   output logic       memwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       iord,
   output logic [3:0] irwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic [1:0] pcsource,
   output logic       pcen,
   output logic [2:0] alucontrol
);

   typedef enum logic [3:0] {
      S_FETCH1  = 4'd0,
      S_FETCH2  = 4'd1,
      S_FETCH3  = 4'd2,
      S_FETCH4  = 4'd3,
      S_DECODE  = 4'd4,
      S_MEMADR  = 4'd5,
      S_LBRD    = 4'd6,
      S_LBWR    = 4'd7,
      S_SBWR    = 4'd8,
      S_RTYPEEX = 4'd9,
      S_RTYPEWR = 4'd10,
      S_BEQEX   = 4'd11,
`ifdef ADDI_EN
      S_JEX     = 4'd12,
      S_ADDIEX  = 4'd13,
      S_ADDIWR  = 4'd14
`else
      S_JEX     = 4'd12
`endif
   } state_t;

   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       iord;
      logic [3:0] irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic [1:0] pcsource;
      logic       pcwrite;
      logic       branch;
      logic [1:0] aluop;
   } ctrl_t;

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic [1:0] aluop_eff;

   // Moore control word for a state; unused encodings yield all zeros.
   function automatic ctrl_t decode_state(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
            c.memread = 1'b1;
            c.irwrite = 4'b0001 << s[1:0];
            c.alusrcb = 2'b01;
            c.pcwrite = 1'b1;
         end
         S_DECODE:  c.alusrcb = 2'b11;
         S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         S_LBRD:    begin c.memread = 1'b1; c.iord = 1'b1; end
         S_LBWR:    begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
         S_SBWR:    begin c.memwrite = 1'b1; c.iord = 1'b1; end
         S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
         S_RTYPEWR: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
         S_BEQEX: begin
            c.alusrca  = 1'b1;
            c.aluop    = 2'b01;
            c.branch   = 1'b1;
            c.pcsource = 2'b01;
         end
         S_JEX:     begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
`ifdef ADDI_EN
         S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         S_ADDIWR:  c.regwrite = 1'b1;
`endif
         default: ;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = S_FETCH1;
      case (state_q)
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: state_d = S_FETCH3;
         S_FETCH3: state_d = S_FETCH4;
         S_FETCH4: state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LB, OP_SB: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_J:         state_d = S_JEX;
`ifdef ADDI_EN
               OP_ADDI:      state_d = S_ADDIEX;
`endif
               default:      state_d = S_FETCH1;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_SB) ? S_SBWR : S_LBRD;
         S_LBRD:    state_d = S_LBWR;
         S_RTYPEEX: state_d = S_RTYPEWR;
`ifdef ADDI_EN
         S_ADDIEX:  state_d = S_ADDIWR;
`endif
         default:   state_d = S_FETCH1;
      endcase
      ctrl_d = decode_state(state_d);
   end

   // Control word is registered alongside the state so outputs come from flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH1;
         ctrl_q  <= decode_state(S_FETCH1);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Reset forces every strobe and select low in the same cycle it is raised.
   assign memread   = ctrl_q.memread  & ~reset;
   assign memwrite  = ctrl_q.memwrite & ~reset;
   assign alusrca   = ctrl_q.alusrca  & ~reset;
   assign alusrcb   = ctrl_q.alusrcb  & {2{~reset}};
   assign iord      = ctrl_q.iord     & ~reset;
   assign irwrite   = ctrl_q.irwrite  & {4{~reset}};
   assign memtoreg  = ctrl_q.memtoreg & ~reset;
   assign regdst    = ctrl_q.regdst   & ~reset;
   assign regwrite  = ctrl_q.regwrite & ~reset;
   assign pcsource  = ctrl_q.pcsource & {2{~reset}};
   assign pcen      = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & zero));
   assign aluop_eff = ctrl_q.aluop    & {2{~reset}};

   always_comb begin
      alucontrol = 3'b010;
      case (aluop_eff)
         2'b00: alucontrol = 3'b010;
         2'b01: alucontrol = 3'b110;
         2'b10: begin
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b101;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mips_controller.sv
// ============================================================================
//  Module   : tb_mips_controller
//  Purpose  : Self-checking bench for mips_controller (honours ADDI_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_controller;

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       iord;
      logic [3:0] irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic [1:0] pcsource;
      logic       pcen;
      logic [2:0] alucontrol;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
   logic [1:0] alusrcb, pcsource;
   logic [3:0] irwrite;
   logic [2:0] alucontrol;

   int   checks = 0;
   int   failures = 0;
   obs_t exp_q[$];
   obs_t trace[$];

   always #5 clk = ~clk;

   mips_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
      .regwrite(regwrite), .pcsource(pcsource), .pcen(pcen), .alucontrol(alucontrol)
   );

   function automatic obs_t snap();
      obs_t s;
      s.memread = memread;   s.memwrite = memwrite; s.alusrca = alusrca;
      s.alusrcb = alusrcb;   s.iord = iord;         s.irwrite = irwrite;
      s.memtoreg = memtoreg; s.regdst = regdst;     s.regwrite = regwrite;
      s.pcsource = pcsource; s.pcen = pcen;         s.alucontrol = alucontrol;
      return s;
   endfunction

   function automatic obs_t idle();
      obs_t c;
      c = '0;
      c.alucontrol = 3'b010;
      return c;
   endfunction

   function automatic logic [2:0] alu_fn(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b101;
      endcase
   endfunction

   // Instruction-level model: one expected observation per cycle of the instruction.
   task automatic model_push(input logic [5:0] o, input logic [5:0] f, input logic z);
      obs_t c;
      for (int k = 0; k < 4; k++) begin
         c = idle(); c.memread = 1'b1; c.irwrite = 4'(1 << k);
         c.alusrcb = 2'b01; c.pcen = 1'b1;
         exp_q.push_back(c);
      end
      c = idle(); c.alusrcb = 2'b11; exp_q.push_back(c);
      if (o == OP_LB || o == OP_SB) begin
         c = idle(); c.alusrca = 1'b1; c.alusrcb = 2'b10; exp_q.push_back(c);
         if (o == OP_LB) begin
            c = idle(); c.memread = 1'b1; c.iord = 1'b1; exp_q.push_back(c);
            c = idle(); c.regwrite = 1'b1; c.memtoreg = 1'b1; exp_q.push_back(c);
         end else begin
            c = idle(); c.memwrite = 1'b1; c.iord = 1'b1; exp_q.push_back(c);
         end
      end else if (o == OP_RTYPE) begin
         c = idle(); c.alusrca = 1'b1; c.alucontrol = alu_fn(f); exp_q.push_back(c);
         c = idle(); c.regwrite = 1'b1; c.regdst = 1'b1; exp_q.push_back(c);
      end else if (o == OP_BEQ) begin
         c = idle(); c.alusrca = 1'b1; c.alucontrol = 3'b110;
         c.pcsource = 2'b01; c.pcen = z; exp_q.push_back(c);
      end else if (o == OP_J) begin
         c = idle(); c.pcen = 1'b1; c.pcsource = 2'b10; exp_q.push_back(c);
      end
`ifdef ADDI_EN
      else if (o == OP_ADDI) begin
         c = idle(); c.alusrca = 1'b1; c.alusrcb = 2'b10; exp_q.push_back(c);
         c = idle(); c.regwrite = 1'b1; exp_q.push_back(c);
      end
`endif
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Entered just after the edge that starts FETCH1; stop_after=0 runs the whole instruction.
   task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int stop_after);
      obs_t e, a;
      int   n;
      op = o; funct = f; zero = z;
      exp_q.delete();
      trace.delete();
      model_push(o, f, z);
      n = 0;
      while (exp_q.size() > 0 && (stop_after == 0 || n < stop_after)) begin
         @(negedge clk);
         e = exp_q.pop_front();
         a = snap();
         trace.push_back(a);
         chk($sformatf("%s_c%0d", name, n), 32'(a), 32'(e));
         n++;
      end
      @(posedge clk);
      #1;
      if (stop_after == 0)
         chk({name, "_refetch"}, 32'({memread, irwrite, memwrite, regwrite}), 32'(7'b1000100));
   endtask

   logic [3:0] irw_lit [4];
   logic       any_rw;

   initial begin
      irw_lit = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      #1;
      chk("reset_outputs", 32'(snap()), 32'(19'h00002));
      @(posedge clk); #1;
      chk("reset_hold", 32'(snap()), 32'(19'h00002));
      @(posedge clk); #1;
      reset = 1'b0;

      run_instr("add", OP_RTYPE, 6'b100000, 1'b0, 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("fetch%0d_irwrite", k), 32'(trace[k].irwrite), 32'(irw_lit[k]));
         chk($sformatf("fetch%0d_pcen_rd", k), 32'({trace[k].pcen, trace[k].memread}), 32'(2'b11));
      end
      chk("add_ex", 32'({trace[5].alucontrol, trace[5].alusrca, trace[5].alusrcb}), 32'(6'b010100));
      chk("add_wr", 32'({trace[6].regwrite, trace[6].regdst, trace[6].memtoreg}), 32'(3'b110));

      run_instr("sub", OP_RTYPE, 6'b100010, 1'b0, 0);
      run_instr("and", OP_RTYPE, 6'b100100, 1'b0, 0);
      run_instr("or",  OP_RTYPE, 6'b100101, 1'b0, 0);
      run_instr("slt", OP_RTYPE, 6'b101010, 1'b0, 0);
      chk("slt_alu", 32'(trace[5].alucontrol), 32'(3'b111));
      run_instr("rill", OP_RTYPE, 6'b000001, 1'b0, 0);
      chk("rill_alu", 32'(trace[5].alucontrol), 32'(3'b101));

      run_instr("lb", OP_LB, 6'd0, 1'b0, 0);
      chk("lb_memadr", 32'(trace[5].alusrcb), 32'(2'b10));
      chk("lb_rd", 32'({trace[6].iord, trace[6].memread}), 32'(2'b11));
      chk("lb_wr", 32'({trace[7].regwrite, trace[7].memtoreg}), 32'(2'b11));

      run_instr("sb", OP_SB, 6'd0, 1'b0, 0);
      chk("sb_wr", 32'({trace[6].memwrite, trace[6].iord}), 32'(2'b11));
      any_rw = 1'b0;
      foreach (trace[i]) any_rw = any_rw | trace[i].regwrite;
      chk("sb_no_regwrite", 32'(any_rw), 32'(0));

      run_instr("beq1", OP_BEQ, 6'd0, 1'b1, 0);
      chk("beq1_ex", 32'({trace[5].pcen, trace[5].pcsource, trace[5].alucontrol}), 32'(6'b101110));
      run_instr("beq0", OP_BEQ, 6'd0, 1'b0, 0);
      chk("beq0_pcen", 32'(trace[5].pcen), 32'(0));
      run_instr("j", OP_J, 6'd0, 1'b0, 0);
      chk("j_ex", 32'({trace[5].pcen, trace[5].pcsource}), 32'(3'b110));

      run_instr("illegal", 6'b111111, 6'd0, 1'b0, 0);
      chk("illegal_len", 32'(trace.size()), 32'(5));

      run_instr("addi", OP_ADDI, 6'd0, 1'b0, 0);
`ifdef ADDI_EN
      chk("addi_wr", 32'({trace[6].regwrite, trace[6].regdst, trace[6].memtoreg}), 32'(3'b100));
`else
      chk("addi_len", 32'(trace.size()), 32'(5));
`endif

      // Reset while LB sits in its memory-read cycle.
      run_instr("lbrst", OP_LB, 6'd0, 1'b0, 6);
      chk("lbrst_in_rd", 32'({memread, iord}), 32'(2'b11));
      reset = 1'b1;
      #1;
      chk("lbrst_same_cycle", 32'(snap()), 32'(19'h00002));
      @(posedge clk); #1;
      chk("lbrst_held", 32'({regwrite, memwrite, memread, pcen}), 32'(0));
      reset = 1'b0;
      #1;
      chk("lbrst_fetch1", 32'({memread, irwrite, regwrite}), 32'(6'b100010));
      run_instr("add2", OP_RTYPE, 6'b100000, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
